// File: rtl/dly_cfg_seq.sv
// Serial configuration sequencer for the ALCT delay-chip groups: shifts words over
// the shared clk_dly/din_dly bus into one selected group and issues the chip reset pulse.
//
// state | meaning
// IDLE  | waiting for start or rst_chips
// RST   | nrs_dly held low for RST_CYC cycles
// SEL   | group selected, clk_dly low, DIV cycles of setup
// SHIFT | one bit per 2*DIV cycles, low half then high half
// HOLD  | clk_dly low, select still active, DIV cycles
// FIN   | one-cycle done strobe, bus released
`timescale 1ns/1ps
module dly_cfg_seq #(
  parameter int NBITS   = 48,
  parameter int DIV     = 2,
  parameter int RST_CYC = 8
) (
  input  logic             clock_mez,
  input  logic             nrst,
  input  logic             start,
  input  logic [1:0]       grp_sel,
  input  logic [5:0]       nbits,
  input  logic [NBITS-1:0] wdata,
  input  logic             rst_chips,
  input  logic             seltst,
  input  logic [3:0]       dout_dly,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NBITS-1:0] rdata,
  output logic             clk_dly,
  output logic             din_dly,
  output logic [3:0]       ncs_dly,
  output logic             nrs_dly,
  output logic             seltst_dly
);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_SEL, S_SHIFT, S_HOLD, S_FIN} state_t;

  localparam int TMAX = (DIV > RST_CYC) ? DIV : RST_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_DIV = TW'(DIV - 1);
  localparam logic [TW-1:0] T_RST = TW'(RST_CYC - 1);
  localparam logic [6:0]    NMAX  = 7'(NBITS);

  state_t           state_q, state_d;
  logic [TW-1:0]    tmr_q;
  logic             phase_q;
  logic [5:0]       bit_q;
  logic [1:0]       grp_q;
  logic [NBITS-1:0] wdata_q;
  logic [NBITS-1:0] rdata_q;
  logic             err_q;
  logic             nbits_ok;
  logic             tmr_tc;

  assign nbits_ok = (nbits != 6'd0) && ({1'b0, nbits} <= NMAX);
  assign tmr_tc   = (tmr_q == '0);
  assign rdata    = rdata_q;
  assign err      = err_q;

  always_ff @(posedge clock_mez or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rst_chips)  state_d = S_RST;
        else if (start) state_d = nbits_ok ? S_SEL : S_FIN;
      end
      S_RST:   if (tmr_tc) state_d = S_FIN;
      S_SEL:   if (tmr_tc) state_d = S_SHIFT;
      S_SHIFT: if (tmr_tc && phase_q && (bit_q == 6'd0)) state_d = S_HOLD;
      S_HOLD:  if (tmr_tc) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Timer and shift datapath; requests arriving while busy only flag err.
  always_ff @(posedge clock_mez or negedge nrst) begin
    if (!nrst) begin
      tmr_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      grp_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      seltst_dly <= 1'b0;
    end else begin
      seltst_dly <= seltst;
      if (busy && (start || rst_chips)) err_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (rst_chips) begin
            tmr_q <= T_RST;
            err_q <= start;
          end else if (start) begin
            if (nbits_ok) begin
              grp_q   <= grp_sel;
              bit_q   <= nbits - 6'd1;
              wdata_q <= wdata;
              rdata_q <= '0;
              err_q   <= 1'b0;
              tmr_q   <= T_DIV;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RST, S_HOLD: begin
          if (!tmr_tc) tmr_q <= tmr_q - 1'b1;
        end
        S_SEL: begin
          if (tmr_tc) begin
            tmr_q   <= T_DIV;
            phase_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_SHIFT: begin
          if (tmr_tc) begin
            tmr_q <= T_DIV;
            if (phase_q) begin
              rdata_q <= {rdata_q[NBITS-2:0], dout_dly[grp_q]};
              phase_q <= 1'b0;
              bit_q   <= bit_q - 6'd1;
            end else begin
              phase_q <= 1'b1;
            end
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    ncs_dly = 4'hF;
    nrs_dly = 1'b1;
    clk_dly = 1'b0;
    din_dly = 1'b0;
    case (state_q)
      S_RST: begin
        busy    = 1'b1;
        nrs_dly = 1'b0;
      end
      S_SEL, S_HOLD: begin
        busy           = 1'b1;
        ncs_dly[grp_q] = 1'b0;
      end
      S_SHIFT: begin
        busy           = 1'b1;
        ncs_dly[grp_q] = 1'b0;
        clk_dly        = phase_q;
        din_dly        = wdata_q[bit_q];
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dly_cfg_seq.sv
// Self-checking bench for dly_cfg_seq: scoreboard of expected completions, with
// dout_dly looped back from din_dly through a flop clocked on clk_dly.
`timescale 1ns/1ps
module tb_dly_cfg_seq;
  localparam int NBITS   = 48;
  localparam int DIV     = 2;
  localparam int RST_CYC = 8;

  logic             clock_mez = 1'b0;
  logic             nrst = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       grp_sel = '0;
  logic [5:0]       nbits = '0;
  logic [NBITS-1:0] wdata = '0;
  logic             rst_chips = 1'b0;
  logic             seltst = 1'b0;
  logic [3:0]       dout_dly;
  logic             busy, done, err, clk_dly, din_dly, nrs_dly, seltst_dly;
  logic [NBITS-1:0] rdata;
  logic [3:0]       ncs_dly;

  dly_cfg_seq #(.NBITS(NBITS), .DIV(DIV), .RST_CYC(RST_CYC)) dut (
    .clock_mez(clock_mez), .nrst(nrst), .start(start), .grp_sel(grp_sel),
    .nbits(nbits), .wdata(wdata), .rst_chips(rst_chips), .seltst(seltst),
    .dout_dly(dout_dly), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .clk_dly(clk_dly), .din_dly(din_dly), .ncs_dly(ncs_dly), .nrs_dly(nrs_dly),
    .seltst_dly(seltst_dly)
  );

  always #12.5 clock_mez = ~clock_mez;

  typedef struct {
    logic [NBITS-1:0] rdata;
    logic             err;
    int               tick;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               tick = 0;
  int               clk_edges = 0;
  int               n_chk = 0;
  int               n_err = 0;
  logic [1:0]       tb_grp = '0;
  logic             loop_q;
  logic [NBITS-1:0] model_rdata = '0;

  always @(posedge clock_mez) tick <= tick + 1;
  always @(posedge clk_dly) clk_edges <= clk_edges + 1;

  // Selected lane returns the looped bit; the other lanes return its inverse.
  always @(posedge clk_dly or negedge nrst) begin
    if (!nrst) loop_q <= 1'b0;
    else       loop_q <= din_dly;
  end
  always_comb begin
    dout_dly         = {4{~loop_q}};
    dout_dly[tb_grp] = loop_q;
  end

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clock_mez) begin
    if (nrst && done) begin
      if (sb.size() == 0) begin
        chk_val("spurious_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk_val("done_cycle", tick, mon_e.tick);
        chk_val("rdata", rdata, mon_e.rdata);
        chk_val("err_at_done", err, mon_e.err);
      end
    end
  end

  task automatic do_shift(input logic [1:0] g, input int n, input logic [NBITS-1:0] w, input int inj);
    exp_t             e;
    int               d, bi, bad_ncs, bad_busy, bad_din;
    logic [NBITS-1:0] m, got;
    m = (n >= NBITS) ? '1 : ((NBITS'(1) << n) - NBITS'(1));
    d = 1 + 2 * DIV * (n + 1);
    bad_ncs = 0; bad_busy = 0; bad_din = 0; got = '0;
    tb_grp = g; grp_sel = g; nbits = 6'(n); wdata = w; start = 1'b1;
    e.rdata = w & m; e.err = (inj > 0); e.tick = tick + d;
    sb.push_back(e);
    model_rdata = w & m;
    @(negedge clock_mez);
    start = 1'b0;
    for (int k = 1; k <= d; k++) begin
      if (k == 1) chk_val("err_cleared", err, 0);
      if (inj > 0 && k == inj) begin
        start = 1'b1; nbits = 6'd3; wdata = '1; grp_sel = g + 2'd1;
      end
      if (inj > 0 && k == inj + 1) begin
        start = 1'b0;
        chk_val("busy_req_err", err, 1);
      end
      if (ncs_dly !== ((k < d) ? ~(4'b0001 << g) : 4'hF)) bad_ncs++;
      if (busy !== (k < d)) bad_busy++;
      if (k >= 1 + DIV && ((k - 1 - DIV) % (2 * DIV)) == 0) begin
        bi = (k - 1 - DIV) / (2 * DIV);
        if (bi < n) got[n - 1 - bi] = din_dly;
      end
      if (k >= d - DIV && k < d && din_dly !== 1'b0) bad_din++;
      @(negedge clock_mez);
    end
    chk_val("ncs_window", bad_ncs, 0);
    chk_val("busy_window", bad_busy, 0);
    chk_val("din_sequence", got, w & m);
    chk_val("din_hold_low", bad_din, 0);
  endtask

  task automatic do_rst(input logic with_start);
    exp_t e;
    int   bad_nrs, bad_ncs, e0;
    bad_nrs = 0; bad_ncs = 0; e0 = clk_edges;
    rst_chips = 1'b1; start = with_start; nbits = 6'd8; wdata = 48'h5A; grp_sel = 2'd1;
    e.rdata = model_rdata; e.err = with_start; e.tick = tick + RST_CYC + 1;
    sb.push_back(e);
    @(negedge clock_mez);
    rst_chips = 1'b0; start = 1'b0;
    for (int k = 1; k <= RST_CYC + 1; k++) begin
      if (nrs_dly !== (k > RST_CYC)) bad_nrs++;
      if (ncs_dly !== 4'hF) bad_ncs++;
      @(negedge clock_mez);
    end
    chk_val("nrs_window", bad_nrs, 0);
    chk_val("rst_ncs_idle", bad_ncs, 0);
    chk_val("rst_no_clk", clk_edges - e0, 0);
  endtask

  task automatic do_invalid(input int n);
    exp_t e;
    int   e0;
    e0 = clk_edges;
    nbits = 6'(n); wdata = '1; grp_sel = 2'd0; start = 1'b1;
    e.rdata = model_rdata; e.err = 1'b1; e.tick = tick + 1;
    sb.push_back(e);
    @(negedge clock_mez);
    start = 1'b0;
    chk_val("inv_err", err, 1);
    chk_val("inv_busy", busy, 0);
    chk_val("inv_ncs", ncs_dly, 4'hF);
    @(negedge clock_mez);
    chk_val("inv_no_clk", clk_edges - e0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

  initial begin
    logic [NBITS-1:0] w;
    int               n;
    repeat (3) @(negedge clock_mez);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_done", done, 0);
    chk_val("rst_err", err, 0);
    chk_val("rst_rdata", rdata, 0);
    chk_val("rst_ncs", ncs_dly, 4'hF);
    chk_val("rst_nrs", nrs_dly, 1);
    chk_val("rst_clk", clk_dly, 0);
    chk_val("rst_din", din_dly, 0);
    chk_val("rst_seltst", seltst_dly, 0);
    nrst = 1'b1;
    @(negedge clock_mez);
    seltst = 1'b1;
    @(negedge clock_mez);
    chk_val("seltst_hi", seltst_dly, 1);
    seltst = 1'b0;
    @(negedge clock_mez);
    chk_val("seltst_lo", seltst_dly, 0);

    do_shift(2'd2, 8, 48'hA5, 0);
    do_rst(1'b0);
    do_invalid(0);
    do_invalid(49);
    do_shift(2'd0, 5, 48'h13, 0);
    do_shift(2'd3, 12, 48'hABC, 10);

    // Asynchronous reset in the middle of a shift.
    tb_grp = 2'd1; grp_sel = 2'd1; nbits = 6'd20; wdata = 48'hF0F0F; start = 1'b1;
    mon_e.rdata = 48'hF0F0F; mon_e.err = 1'b0; mon_e.tick = tick + 1 + 2 * DIV * 21;
    sb.push_back(mon_e);
    @(negedge clock_mez);
    start = 1'b0;
    repeat (14) @(negedge clock_mez);
    chk_val("pre_abort_busy", busy, 1);
    nrst = 1'b0;
    #1;
    sb.delete();
    model_rdata = '0;
    chk_val("abort_busy", busy, 0);
    chk_val("abort_done", done, 0);
    chk_val("abort_ncs", ncs_dly, 4'hF);
    chk_val("abort_clk", clk_dly, 0);
    chk_val("abort_din", din_dly, 0);
    chk_val("abort_rdata", rdata, 0);
    @(negedge clock_mez);
    nrst = 1'b1;
    repeat (6) @(negedge clock_mez);
    do_shift(2'd0, 48, '1, 0);

    do_rst(1'b1);
    chk_val("err_after_dual", err, 1);

    for (int i = 0; i < 3; i++) begin
      n = $urandom_range(1, NBITS);
      w = {16'($urandom), $urandom};
      do_shift(2'($urandom_range(0, 3)), n, w, 0);
    end

    repeat (3) @(negedge clock_mez);
    chk_val("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dly_cfg_seq.md
# dly_cfg_seq

Serial configuration sequencer for the ALCT delay-chip groups on the mezzanine. It drives the shared clk_dly/din_dly lines and selects one of four groups via ncs_dly, so host logic can load delay/pattern words and read back the chain output. It also issues the chip reset pulse on nrs_dly and registers the test-select level. It sits between the slow-control/JTAG register block and the delay-chip pins, so only one requester owns the shared serial bus at a time.

## Interface
- NBITS, 48, maximum shift length per transaction (rdata/wdata width)
- DIV, 2, clk_dly half-period in clock_mez cycles (>=1)
- RST_CYC, 8, nrs_dly low duration in clock_mez cycles
- clock_mez  in  1  40 MHz mezzanine clock, all logic on rising edge
- nrst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to shift a word
- grp_sel  in  2  delay-chip group to address (ncs_dly index)
- nbits  in  6  bits to shift, valid range 1..NBITS
- wdata  in  NBITS  word to shift, MSB-first from bit nbits-1
- rst_chips  in  1  one-cycle request for a chip reset pulse
- seltst  in  1  test-select level
- dout_dly  in  4  serial return, one per group
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion strobe
- err  out  1  sticky error flag, cleared by the next accepted request
- rdata  out  NBITS  captured return bits, last bit in bit 0
- clk_dly, din_dly  out  1 each  shared serial clock/data
- ncs_dly  out  4  active-low group selects
- nrs_dly  out  1  active-low chip reset
- seltst_dly  out  1  registered seltst

## Operation
- FSM states: IDLE, RST, SEL, SHIFT, HOLD, FIN.
- IDLE, with rst_chips=1: go to RST; nrs_dly=0 for RST_CYC cycles, then FIN. rst_chips has priority over start. A start in the same cycle is dropped and sets err.
- IDLE, with start=1 and 1<=nbits<=NBITS: latch grp_sel, nbits and wdata, clear err and rdata, go to SEL.
- IDLE, with start=1 and nbits out of range: set err, go directly to FIN with no pin activity.
- SEL: ncs_dly[grp]=0 and clk_dly=0 for DIV cycles.
- SHIFT: each bit is DIV cycles with clk_dly=0 followed by DIV cycles with clk_dly=1.
  - din_dly is updated on the first low cycle: first wdata[nbits-1], then down to wdata[0].
  - dout_dly[grp] is sampled on the last high cycle: rdata <= {rdata[NBITS-2:0], dout}.
  - After nbits bits, go to HOLD.
- HOLD: clk_dly=0, ncs still low, for DIV cycles.
- FIN: one cycle. ncs_dly=4'hF, nrs_dly=1, done=1, busy=0. Then IDLE.
- busy=1 in every state except IDLE and FIN.
- start or rst_chips while busy: ignored, and err set.
- Only one ncs_dly bit is ever low.
- din_dly returns to 0 in HOLD.
- seltst_dly <= seltst every cycle, independent of the FSM.

## Timing
- Reset values (asynchronous on nrst=0, also mid-transaction):
  - ncs_dly=4'hF, nrs_dly=1, clk_dly=0, din_dly=0, seltst_dly=0
  - busy=0, done=0, err=0, rdata=0, FSM=IDLE
- Any transaction in progress is aborted with no done strobe.
- Cycle numbering: cycle 0 is the cycle in which start is sampled.
- Shift transaction:
  - ncs low and busy high from cycle 1.
  - Bit k: clk_dly low during cycles 1+DIV+2·DIV·k .. DIV·(2k+2), high during the next DIV cycles.
  - done at cycle 1+2·DIV·(nbits+1). rdata is valid in that same cycle and holds until the next accepted request.
- Reset pulse: nrs_dly low during cycles 1..RST_CYC, done at cycle RST_CYC+1.
- Invalid nbits: err=1 and done=1 at cycle 1.
- Back-to-back: a start in the FIN cycle is ignored. The earliest accepted next start is the cycle after FIN.

## Test plan
- DIV=2, grp_sel=2, nbits=8, wdata=0xA5, dout_dly[2] looped from din_dly through a one-clk_dly-edge model:
  - only ncs_dly=4'b1011 goes low, cycles 1–36
  - din sequence 1,0,1,0,0,1,0,1
  - done at cycle 37, rdata[7:0]=0xA5, err=0.
- rst_chips pulse with RST_CYC=8:
  - nrs_dly low for exactly cycles 1–8, done at cycle 9
  - ncs_dly stays 4'hF.
- start with nbits=0, then with nbits=49 (NBITS=48):
  - err=1 and done at cycle 1, no clk_dly edges.
  - A following valid start clears err.
- start asserted at cycle 10 of an active transaction:
  - ignored, err=1
  - first transaction completes at its original done cycle with correct rdata.
- nrst pulsed low mid-SHIFT (cycle 15):
  - all outputs at reset values immediately, no done strobe
  - a subsequent start with nbits=NBITS=48, wdata=all-ones completes at cycle 197.
- start and rst_chips in the same cycle:
  - reset pulse performed, no ncs activity, err=1.
